// File: rtl/clken_gen_pkg.sv
// Shared types, default constants and configuration clamps for the clock-enable generator.
package clken_gen_pkg;

  // Controller states: settling, running, and one-cycle register update.
  typedef enum logic [1:0] {
    LOCKING = 2'd0,
    LOCKED  = 2'd1,
    APPLY   = 2'd2
  } state_t;

  localparam int DEFAULT_NUM_CLOCKS  = 4;
  localparam int DEFAULT_CNT_W       = 16;
  localparam int DEFAULT_DIV_RATIO   = 2;
  localparam int DEFAULT_LOCK_CYCLES = 256;

  // A divide ratio of zero has no meaning; treat it as divide-by-one.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

  // The strobe offset must land inside the period, so pin it to the last count.
  function automatic logic [31:0] clamp_phase(input logic [31:0] div,
                                              input logic [31:0] phase);
    return (phase >= div) ? (div - 32'd1) : phase;
  endfunction

endpackage

// File: rtl/clken_gen_channel.sv
// One output channel: stored divide/phase, free-running period counter and raw compares.
module clken_gen_channel
  import clken_gen_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int DEFAULT_DIV = DEFAULT_DIV_RATIO
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             run,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_phase,
  output logic             outclk_en,
  output logic             outclk
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(clamp_div(32'(DEFAULT_DIV)));

  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] phase_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] new_div;
  logic [CNT_W-1:0] new_phase;
  logic [CNT_W:0]   high_len;
  logic             last_cnt;

  // Phase is clamped against the divide value being written alongside it.
  assign new_div   = CNT_W'(clamp_div(32'(wr_div)));
  assign new_phase = CNT_W'(clamp_phase(32'(new_div), 32'(wr_phase)));

  // Configuration registers, updated only while the controller is applying a change.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      div_reg   <= DIV_RST;
      phase_reg <= '0;
    end else if (wr_en) begin
      div_reg   <= new_div;
      phase_reg <= new_phase;
    end
  end

  assign last_cnt = (cnt_reg == (div_reg - CNT_W'(1)));

  // Period counter: parked at 0 until locked so every channel starts on the same edge.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (!run || last_cnt) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // High time is ceil(div/2), so odd ratios get the extra cycle in the high half.
  assign high_len  = ({1'b0, div_reg} + (CNT_W+1)'(1)) >> 1;
  assign outclk_en = (cnt_reg == phase_reg);
  assign outclk    = ({1'b0, cnt_reg} < high_len);

endmodule

// File: rtl/clken_gen_multi.sv
// Multi-channel clock-enable generator: lock controller, config decode and output gating.
module clken_gen_multi
  import clken_gen_pkg::*;
#(
  parameter int NUM_CLOCKS  = DEFAULT_NUM_CLOCKS,
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int DEFAULT_DIV = DEFAULT_DIV_RATIO,
  parameter int LOCK_CYCLES = DEFAULT_LOCK_CYCLES,
  parameter int CH_W        = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [CNT_W-1:0]      cfg_div,
  input  logic [CNT_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int              LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [LOCK_W-1:0] lock_cnt_reg;
  logic [LOCK_W-1:0] lock_cnt_next;
  logic [CH_W-1:0]   pend_ch_reg;
  logic [CNT_W-1:0]  pend_div_reg;
  logic [CNT_W-1:0]  pend_phase_reg;
  logic              cfg_fire;
  logic              ch_ok;
  logic [NUM_CLOCKS-1:0] ch_en;
  logic [NUM_CLOCKS-1:0] ch_clk;

  // Ready is also gated by the reset pin so it reads 0 while reset is held.
  assign cfg_ready = rst && (state_reg != APPLY);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign ch_ok     = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CLOCKS));
  assign locked    = (state_reg == LOCKED);

  // State and settling-counter registers.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_reg    <= LOCKING;
      lock_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  // Next state: a valid-channel request always detours through APPLY and restarts settling.
  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = lock_cnt_reg;
    case (state_reg)
      LOCKING: begin
        if (cfg_fire && ch_ok) begin
          state_next = APPLY;
        end else if (lock_cnt_reg == LOCK_LAST) begin
          state_next = LOCKED;
        end else begin
          lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
        end
      end
      LOCKED: begin
        if (cfg_fire && ch_ok) begin
          state_next = APPLY;
        end
      end
      APPLY: begin
        state_next    = LOCKING;
        lock_cnt_next = '0;
      end
      default: begin
        state_next    = LOCKING;
        lock_cnt_next = '0;
      end
    endcase
  end

  // Hold the accepted request so APPLY can write it into the selected channel.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      pend_ch_reg    <= '0;
      pend_div_reg   <= '0;
      pend_phase_reg <= '0;
    end else if (cfg_fire && ch_ok) begin
      pend_ch_reg    <= cfg_ch;
      pend_div_reg   <= cfg_div;
      pend_phase_reg <= cfg_phase;
    end
  end

  for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_ch
    logic wr_en;
    assign wr_en = (state_reg == APPLY) && (pend_ch_reg == CH_W'(gi));

    clken_gen_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .refclk    (refclk),
      .rst       (rst),
      .run       (locked),
      .wr_en     (wr_en),
      .wr_div    (pend_div_reg),
      .wr_phase  (pend_phase_reg),
      .outclk_en (ch_en[gi]),
      .outclk    (ch_clk[gi])
    );
  end

  // Nothing reaches the outputs unless every channel is running in alignment.
  assign outclk_en = ch_en  & {NUM_CLOCKS{locked}};
  assign outclk    = ch_clk & {NUM_CLOCKS{locked}};

endmodule

// File: tb/tb_clken_gen_multi.sv
// Scoreboard bench: stimulus pushes expected per-cycle outputs, a negedge monitor compares.
module tb_clken_gen_multi;

  localparam int NCH      = 3;
  localparam int CNT_W    = 16;
  localparam int LOCK_CYC = 8;
  localparam int CH_W     = 2;

  logic             refclk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic [CNT_W-1:0] cfg_phase = '0;
  logic [NCH-1:0]   outclk_en;
  logic [NCH-1:0]   outclk;
  logic             locked;

  always #5 refclk = ~refclk;

  clken_gen_multi #(
    .NUM_CLOCKS  (NCH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (2),
    .LOCK_CYCLES (LOCK_CYC)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .outclk_en (outclk_en),
    .outclk    (outclk),
    .locked    (locked)
  );

  // Expected vector layout: {locked, cfg_ready, outclk_en[2:0], outclk[2:0]}
  logic [7:0] exp_q[$];
  int         tag_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         exp_div[NCH];
  int         exp_phase[NCH];
  int         n_run;
  int         scn;
  logic [7:0] mon_e;
  logic [7:0] mon_g;
  int         mon_t;

  // Expected outputs for the current cycle; while locked, channel i is at count n_run mod div.
  task automatic push_exp(input bit lk, input bit rdy);
    logic [NCH-1:0] en;
    logic [NCH-1:0] ck;
    en = '0;
    ck = '0;
    if (lk) begin
      for (int i = 0; i < NCH; i++) begin
        int m;
        m = n_run % exp_div[i];
        en[i] = (m == exp_phase[i]);
        ck[i] = ((2 * m) < exp_div[i]);
      end
      n_run++;
    end
    exp_q.push_back({lk, rdy, en, ck});
    tag_q.push_back(scn);
  endtask

  task automatic nxt();
    @(posedge refclk);
    #1;
  endtask

  task automatic cyc_locked(input int n);
    repeat (n) begin
      nxt();
      push_exp(1'b1, 1'b1);
    end
  endtask

  task automatic cyc_unlocked(input int n, input bit rdy);
    repeat (n) begin
      nxt();
      push_exp(1'b0, rdy);
    end
  endtask

  // Request issued in the current cycle; the next cycle is APPLY.
  task automatic do_cfg(input int ch, input int dv, input int ph);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = CNT_W'(dv);
    cfg_phase = CNT_W'(ph);
    nxt();
    cfg_valid = 1'b0;
    push_exp(1'b0, 1'b0);
  endtask

  task automatic relock();
    cyc_unlocked(LOCK_CYC, 1'b1);
    n_run = 0;
  endtask

  // Monitor: one comparison and one line per sampled cycle.
  always @(negedge refclk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_g = {locked, cfg_ready, outclk_en, outclk};
      n_checks++;
      if (mon_g !== mon_e) begin
        n_fail++;
        $display("FAIL scn%0d outputs: got locked=%b ready=%b en=%b clk=%b, required locked=%b ready=%b en=%b clk=%b",
                 mon_t, mon_g[7], mon_g[6], mon_g[5:3], mon_g[2:0],
                 mon_e[7], mon_e[6], mon_e[5:3], mon_e[2:0]);
      end else begin
        $display("ok   scn%0d locked=%b ready=%b en=%b clk=%b",
                 mon_t, mon_g[7], mon_g[6], mon_g[5:3], mon_g[2:0]);
      end
    end
  end

  initial begin
    for (int i = 0; i < NCH; i++) begin
      exp_div[i]   = 2;
      exp_phase[i] = 0;
    end
    n_run = 0;

    // Reset held: everything low, not ready
    scn = 0;
    repeat (3) begin
      nxt();
      push_exp(1'b0, 1'b0);
    end

    // Release: locked rises at edge 8, defaults div=2 phase=0 on every channel
    scn = 1;
    nxt();
    rst = 1'b1;
    push_exp(1'b0, 1'b1);
    cyc_unlocked(LOCK_CYC - 1, 1'b1);
    n_run = 0;
    cyc_locked(6);

    // ch1 div=5 phase=3: strobe at count 3, high 3 / low 2
    scn = 2;
    do_cfg(1, 5, 3);
    relock();
    exp_div[1]   = 5;
    exp_phase[1] = 3;
    cyc_locked(12);

    // ch2 div=0 behaves as divide-by-one
    scn = 3;
    do_cfg(2, 0, 0);
    relock();
    exp_div[2]   = 1;
    exp_phase[2] = 0;
    cyc_locked(4);

    // ch0 div=4 phase=7 clamps to phase 3
    scn = 4;
    do_cfg(0, 4, 7);
    relock();
    exp_div[0]   = 4;
    exp_phase[0] = 3;
    cyc_locked(9);

    // Out-of-range channel while locked: consumed, no disturbance
    scn = 5;
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(3);
    cfg_div   = CNT_W'(7);
    cfg_phase = CNT_W'(1);
    nxt();
    cfg_valid = 1'b0;
    push_exp(1'b1, 1'b1);
    cyc_locked(6);

    // Back-to-back: second request during LOCKING restarts settling
    scn = 6;
    do_cfg(1, 3, 1);
    cyc_unlocked(3, 1'b1);
    do_cfg(1, 6, 2);
    relock();
    exp_div[1]   = 6;
    exp_phase[1] = 2;
    cyc_locked(13);

    // Reset mid-period: outputs drop without an edge, defaults come back
    scn = 7;
    nxt();
    rst = 1'b0;
    push_exp(1'b0, 1'b0);
    repeat (2) begin
      nxt();
      push_exp(1'b0, 1'b0);
    end
    for (int i = 0; i < NCH; i++) begin
      exp_div[i]   = 2;
      exp_phase[i] = 0;
    end
    nxt();
    rst = 1'b1;
    push_exp(1'b0, 1'b1);
    cyc_unlocked(LOCK_CYC - 1, 1'b1);
    n_run = 0;
    cyc_locked(6);

    nxt();
    nxt();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
